// File: rtl/instr_encoder_pkg.sv
// Shared RV32I opcode constants and instruction-format enum.
// Used by both the field encoder and the core's field decoder.
package instr_encoder_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    f = FMT_BAD;
    unique case (1'b1)
      op == OP_R:      f = FMT_R;
      op == OP_IMM,
      op == OP_LOAD,
      op == OP_JALR:   f = FMT_I;
      op == OP_STORE:  f = FMT_S;
      op == OP_BRANCH: f = FMT_B;
      op == OP_LUI,
      op == OP_AUIPC:  f = FMT_U;
      op == OP_JAL:    f = FMT_J;
      default:         f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Synchronous FIFO holding encoded words ahead of the memory writer.
// Ports: wr_en_i/wr_data_i push, rd_en_i pop, rd_data_o head, full/empty/count.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr, rd;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign wr      = wr_en_i && !full_o;
  assign rd      = rd_en_i && !empty_o;

  // Head reads as zero when nothing is queued.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr, rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs RV32I fields into instruction words and streams them with addresses.
// Ports: in_* field handshake, out_* word/addr handshake, err pulse, count.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               opcode,
  input  logic [4:0]               rd,
  input  logic [2:0]               f3,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic                     f7,
  input  logic [31:0]              imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count
);

  fmt_e              fmt;
  logic              shift;
  logic              accept;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [31:0]       word;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  assign fmt    = fmt_of(opcode);
  assign shift  = (opcode == OP_IMM) &&
                  ((f3 == 3'b001) || (f3 == 3'b101));
  assign accept = in_valid && in_ready;
  assign push   = accept && (fmt != FMT_BAD);
  assign pop    = out_valid && out_ready;

  // Depends only on registered occupancy, so a pop never
  // opens in_ready in the same cycle.
  assign in_ready  = !full;
  assign out_valid = !empty;

  always_comb begin
    word = '0;
    unique case (fmt)
      FMT_R:
        word = {1'b0, f7, 5'b0, rs2, rs1, f3, rd, opcode};
      FMT_I:
        if (shift)
          word = {1'b0, f7, 5'b0, imm[4:0], rs1, f3, rd, opcode};
        else
          word = {imm[11:0], rs1, f3, rd, opcode};
      FMT_S:
        word = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
      FMT_B:
        word = {imm[12], imm[10:5], rs2, rs1, f3,
                imm[4:1], imm[11], opcode};
      FMT_U:
        word = {imm[31:12], rd, opcode};
      FMT_J:
        word = {imm[20], imm[10:1], imm[11],
                imm[19:12], rd, opcode};
      default:
        word = '0;
    endcase
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (word),
    .rd_en_i   (pop),
    .rd_data_o (out_instr),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (count)
  );

  // Address tracks the head word; wraps silently.
  assign addr_d = pop ? addr_q + 1'b1 : addr_q;
  assign err_d  = accept && (fmt == FMT_BAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= ADDR_W'(BASE_ADDR);
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  assign out_addr = addr_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-encoded RV32I words.
// Negedge scoreboard tracks queue contents, addresses and err.
module tb_instr_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        f7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_addr;
  logic        err;
  logic [2:0]  count;

  instr_encoder #(
    .DEPTH     (4),
    .ADDR_W    (2),
    .BASE_ADDR (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rd        (rd),
    .f3        (f3),
    .rs1       (rs1),
    .rs2       (rs2),
    .f7        (f7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        f7;
    logic [31:0] imm;
    logic [31:0] exp;
    bit          legal;
  } vec_t;

  vec_t tv [17];

  function automatic vec_t mk(
    input logic [6:0] op, input logic [4:0] d,
    input logic [2:0] fn3, input logic [4:0] s1,
    input logic [4:0] s2, input logic fn7,
    input logic [31:0] im, input logic [31:0] ex,
    input bit ok);
    vec_t v;
    v.op = op; v.rd = d; v.f3 = fn3;
    v.rs1 = s1; v.rs2 = s2; v.f7 = fn7;
    v.imm = im; v.exp = ex; v.legal = ok;
    return v;
  endfunction

  initial begin
    tv[0]  = mk(7'h33, 3, 0, 1, 2, 0, 32'h0, 32'h002081B3, 1);
    tv[1]  = mk(7'h33, 3, 0, 1, 2, 1, 32'h0, 32'h402081B3, 1);
    tv[2]  = mk(7'h13, 5, 0, 0, 0, 0, 32'hFFFFFFFF,
                32'hFFF00293, 1);
    tv[3]  = mk(7'h23, 0, 2, 1, 2, 0, 32'h8, 32'h0020A423, 1);
    tv[4]  = mk(7'h63, 0, 0, 1, 2, 0, 32'h8, 32'h00208463, 1);
    tv[5]  = mk(7'h37, 1, 0, 0, 0, 0, 32'h12345000,
                32'h123450B7, 1);
    tv[6]  = mk(7'h6F, 1, 0, 0, 0, 0, 32'h10, 32'h010000EF, 1);
    tv[7]  = mk(7'h13, 1, 1, 2, 7, 0, 32'hFFFFFFE3,
                32'h00311093, 1);
    tv[8]  = mk(7'h13, 1, 5, 2, 0, 1, 32'h3, 32'h40315093, 1);
    tv[9]  = mk(7'h03, 5, 2, 1, 0, 0, 32'hFFFFFFFC,
                32'hFFC0A283, 1);
    tv[10] = mk(7'h17, 2, 0, 0, 0, 0, 32'h1000, 32'h00001117, 1);
    tv[11] = mk(7'h6F, 0, 0, 0, 0, 0, 32'hFFFFFFFC,
                32'hFFDFF06F, 1);
    tv[12] = mk(7'h63, 0, 0, 0, 0, 0, 32'hFFFFFFFC,
                32'hFE000EE3, 1);
    tv[13] = mk(7'h67, 0, 0, 1, 0, 0, 32'h0, 32'h00008067, 1);
    tv[14] = mk(7'h00, 1, 0, 1, 2, 0, 32'h0, 32'h0, 0);
    tv[15] = mk(7'h7F, 1, 0, 1, 2, 0, 32'h0, 32'h0, 0);
    tv[16] = mk(7'h33, 10, 7, 11, 12, 0, 32'h0, 32'h00C5F533, 1);
  end

  logic [31:0] cur_exp;
  bit          cur_legal;
  bit          mon_en = 0;
  logic [31:0] q [$];
  logic [1:0]  exp_addr;
  logic        err_exp;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("m_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_ready", 32'(in_ready), 32'(q.size() < 4));
      chk("m_err", 32'(err), 32'(err_exp));
      if (q.size() != 0) begin
        chk("m_instr", out_instr, q[0]);
        chk("m_addr", 32'(out_addr), 32'(exp_addr));
      end
      if (rst) begin
        q.delete();
        exp_addr = 2'd0;
        err_exp  = 1'b0;
      end else begin
        if (out_valid && out_ready && q.size() != 0) begin
          void'(q.pop_front());
          exp_addr = exp_addr + 2'd1;
        end
        err_exp = in_valid && in_ready && !cur_legal;
        if (in_valid && in_ready && cur_legal)
          q.push_back(cur_exp);
      end
    end
  end

  task automatic drive(input int i);
    opcode    = tv[i].op;
    rd        = tv[i].rd;
    f3        = tv[i].f3;
    rs1       = tv[i].rs1;
    rs2       = tv[i].rs2;
    f7        = tv[i].f7;
    imm       = tv[i].imm;
    cur_exp   = tv[i].exp;
    cur_legal = tv[i].legal;
  endtask

  task automatic send(input int i);
    bit ok;
    bit done;
    done = 0;
    drive(i);
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) done = 1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 50 && count != 0; k++) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(count), 0);
  endtask

  initial begin
    logic [2:0] c0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_addr  = 2'd0;
    err_exp   = 1'b0;
    cur_exp   = '0;
    cur_legal = 1'b1;
    drive(0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_addr", 32'(out_addr), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_count", 32'(count), 0);
    mon_en = 1;

    // One word at a time; first checks one-cycle latency.
    send(0);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_instr", out_instr, 32'h002081B3);
    chk("lat_addr", 32'(out_addr), 0);
    drain();
    for (int i = 1; i < 17; i++) begin
      if (tv[i].legal) begin
        send(i);
        drain();
      end
    end

    // Streaming with the writer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      chk("thru_ready", 32'(in_ready), 1);
      send(i);
      chk("thru_count", 32'(count), 1);
    end
    drain();

    // Backpressure: fill, then release.
    for (int i = 0; i < 4; i++) send(i);
    chk("full_ready", 32'(in_ready), 0);
    chk("full_count", 32'(count), 4);
    drive(4);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("full_nocomb", 32'(in_ready), 0);
    in_valid = 1'b0;
    send(4);
    drain();

    // Illegal opcodes: dropped, err pulses.
    out_ready = 1'b0;
    send(2);
    c0 = count;
    send(14);
    chk("ill_err", 32'(err), 1);
    chk("ill_count", 32'(count), 32'(c0));
    @(posedge clk);
    #1;
    chk("ill_err_end", 32'(err), 0);
    send(14);
    chk("ill_b2b_1", 32'(err), 1);
    send(15);
    chk("ill_b2b_2", 32'(err), 1);
    @(posedge clk);
    #1;
    chk("ill_b2b_end", 32'(err), 0);
    send(5);
    chk("ill_count2", 32'(count), 2);
    drain();

    // Reset with words queued and input offered.
    for (int i = 0; i < 3; i++) send(i);
    chk("pre_rst_count", 32'(count), 3);
    drive(3);
    in_valid = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_addr", 32'(out_addr), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    send(6);
    chk("post_rst_addr", 32'(out_addr), 0);
    chk("post_rst_instr", out_instr, 32'h010000EF);
    drain();

    repeat (2) @(posedge clk);
    #1;
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
